pe_bus_interconnect: RTL
========================

# pe_bus_interconnect

Parametrised CPU-side memory-mapped interconnect for the manycore processing element. It generalises the fixed boot/RAM/peripheral/DDMA address mux into NUM_SLAVES mask-decoded regions with a ready handshake, so slaves may insert wait states. It adds per-slave byte-lane swap, sticky bus-error capture with an interrupt, and an optional access timeout. It sits between core_rv32e and the PE's memories and peripherals.

## Interface
- DATA_WIDTH, 32, CPU and slave data and address width.
- NUM_SLAVES, 4, number of decoded regions (1..16).
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed base addresses; slave i is bits [32*i+31:32*i].
- SLAVE_MASK, {NUM_SLAVES{32'hE0000000}}, packed decode masks, same packing.
- SWAP_MASK, 0, NUM_SLAVES bits; bit i set byte-reverses wdata to and rdata from slave i.
- TIMEOUT_CYCLES, 255, ACCESS-state cycles before timeout (1..65535). Used only with PE_BUS_TIMEOUT_EN.
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req_in  in  1  access request; CPU holds addr/data/wb while cpu_stall_out is high.
- cpu_addr_in  in  DATA_WIDTH  byte address.
- cpu_wdata_in  in  DATA_WIDTH  write data.
- cpu_wb_in  in  4  byte write enables; 0 means read.
- cpu_rdata_out  out  DATA_WIDTH  read data, registered.
- cpu_stall_out  out  1  CPU hold.
- s_sel_out  out  NUM_SLAVES  one-hot slave select, registered.
- s_addr_out  out  DATA_WIDTH  shared word-aligned address (addr & ~3), registered.
- s_wdata_out  out  DATA_WIDTH  shared write data, swapped per SWAP_MASK, registered.
- s_wb_out  out  4  shared byte enables, registered.
- s_rdata_in  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- s_ready_in  in  NUM_SLAVES  per-slave completion.
- err_irq_out  out  1  sticky bus-error interrupt.
- err_cause_out  out  2  01 decode miss, 10 timeout, 00 none.
- err_addr_out  out  DATA_WIDTH  address of the first faulting access.
- err_clr_in  in  1  clears the error record.

## Operation
- Decode: slave i hits when (cpu_addr_in & SLAVE_MASK[i]) == SLAVE_BASE[i]. The lowest hitting index wins.
- FSM states: IDLE, ACCESS, RESP.
- IDLE with cpu_req_in and a hit:
  - Latch the slave index, aligned address, swapped wdata and wb.
  - Move to ACCESS.
- IDLE with cpu_req_in and a miss:
  - Record a decode-miss error.
  - Force rdata to 0 and drop any write.
  - Move to RESP.
- ACCESS:
  - s_sel_out[idx] is 1; s_addr/wdata/wb are held stable.
  - On s_ready_in[idx], latch s_rdata_in slice idx (swapped if SWAP_MASK[idx]) into cpu_rdata_out, clear sel and move to RESP.
  - s_ready_in bits of unselected slaves are ignored.
- RESP:
  - cpu_rdata_out is valid and the stall is released.
  - Always move to IDLE; a cpu_req_in seen in RESP is not accepted.
  - Writes leave cpu_rdata_out at 0.
- Error record:
  - The first error sets err_irq_out, err_cause_out and err_addr_out. Later errors are ignored while err_irq_out is 1.
  - err_clr_in clears all three next cycle.
  - If err_clr_in and a new error occur in the same cycle, the new error is recorded.
- Reset mid-access: the FSM returns to IDLE, the selected slave is deselected and the in-flight access is abandoned.

## Timing
- cpu_stall_out = (IDLE & cpu_req_in) | ACCESS. It is combinational from the request, registered otherwise.
- Zero-wait slave (ready in the first ACCESS cycle): the request is presented in cycle 0, sel is high in cycle 1, rdata is valid in cycle 2 with stall low. Each wait state adds 1 cycle.
- Decode miss: rdata is 0 in cycle 1; err_irq_out rises in cycle 1.
- Reset values:
  - state IDLE.
  - cpu_rdata_out, s_sel_out, s_addr_out, s_wdata_out, s_wb_out all 0.
  - err_irq_out 0, err_cause_out 00, err_addr_out 0.
  - cpu_stall_out follows cpu_req_in.

## Configuration
- PE_BUS_TIMEOUT_EN defined:
  - A 16-bit counter clears on ACCESS entry and increments each ACCESS cycle without ready.
  - When the count reaches TIMEOUT_CYCLES, the access is deselected, rdata is forced to 0, cause 10 is recorded and the FSM moves to RESP.
  - Ready in the same cycle as expiry counts as success.
- PE_BUS_TIMEOUT_EN undefined:
  - No counter exists; ACCESS waits for ready indefinitely.
  - Cause 10 is never produced.

## Test plan
- Read slave 1 (base 40000000, mask E0000000, no swap), ready in the first ACCESS cycle, rdata 11223344 -> sel=0010 in cycle 1, cpu_rdata_out=11223344 with stall low in cycle 2.
- Write to a SWAP_MASK slave, wdata AABBCCDD, wb=1111, ready after 3 wait cycles -> s_wdata_out=DDCCBBAA, stall high for 4 ACCESS cycles, rdata 0.
- Read 30000000 with no region hit -> no sel, rdata 0 in cycle 1, err_irq_out=1, cause 01, err_addr 30000000; a second miss leaves err_addr unchanged; err_clr_in clears the record.
- With PE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, the slave never readies -> sel drops after 4 ACCESS cycles, rdata 0, cause 10; without the macro, stall stays high past 100 cycles.
- Assert reset in the middle of ACCESS -> sel 0 and state IDLE immediately; the next request completes normally.
- Overlapping regions 0 and 2 both hit -> only sel[0] is asserted.

Source files
------------

// File: rtl/pe_bus_interconnect.sv
// pe_bus_interconnect: mask-decoded CPU-to-slave bus with wait states, per-slave byte swap and sticky error capture.
// Optional access timeout is compiled in when PE_BUS_TIMEOUT_EN is defined.
module pe_bus_interconnect #(
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hE0000000}},
    parameter logic [NUM_SLAVES-1:0]    SWAP_MASK      = '0,
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cpu_req_in,
    input  logic [DATA_WIDTH-1:0]            cpu_addr_in,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata_in,
    input  logic [3:0]                       cpu_wb_in,
    output logic [DATA_WIDTH-1:0]            cpu_rdata_out,
    output logic                             cpu_stall_out,
    output logic [NUM_SLAVES-1:0]            s_sel_out,
    output logic [DATA_WIDTH-1:0]            s_addr_out,
    output logic [DATA_WIDTH-1:0]            s_wdata_out,
    output logic [3:0]                       s_wb_out,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_in,
    input  logic [NUM_SLAVES-1:0]            s_ready_in,
    output logic                             err_irq_out,
    output logic [1:0]                       err_cause_out,
    output logic [DATA_WIDTH-1:0]            err_addr_out,
    input  logic                             err_clr_in,
    output logic [1:0]                       dbg_state_out   // 0 IDLE, 1 ACCESS, 2 RESP
);

    // Handshake: the CPU holds req/addr/wdata/wb while stall is high; a slave
    // completes by raising its ready bit while its sel bit is high, and the
    // result is presented on cpu_rdata_out in the cycle stall drops (RESP).

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("pe_bus_interconnect: parameter out of range");
    end

    function automatic logic [DATA_WIDTH-1:0] swap_bytes(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            r[8*b +: 8] = d[DATA_WIDTH-8-8*b +: 8];
        end
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wb_q, wb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_irq_q, err_irq_d;
    logic [1:0]              err_cause_q, err_cause_d;
    logic [DATA_WIDTH-1:0]   err_addr_q, err_addr_d;

    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    ready_sel;
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic                    tmo_hit;
    logic                    miss_err;
    logic                    tmo_err;

    // Descending scan so the lowest hitting index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr_in[31:0] & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign ready_sel = s_ready_in[idx_q];
    assign rdata_sel = s_rdata_in[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef PE_BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_ACCESS && !ready_sel) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Expires on the ACCESS cycle whose increment would reach the limit.
    assign tmo_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_q        <= '0;
            rdata_q     <= '0;
            err_irq_q   <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_q        <= wb_d;
            rdata_q     <= rdata_d;
            err_irq_q   <= err_irq_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_req_in) state_d = hit ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (ready_sel || tmo_hit) state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wb_d     = wb_q;
        rdata_d  = rdata_q;
        miss_err = 1'b0;
        tmo_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_in && hit) begin
                    idx_d          = hit_idx;
                    sel_d          = '0;
                    sel_d[hit_idx] = 1'b1;
                    addr_d         = {cpu_addr_in[DATA_WIDTH-1:2], 2'b00};
                    wdata_d        = SWAP_MASK[hit_idx] ? swap_bytes(cpu_wdata_in) : cpu_wdata_in;
                    wb_d           = cpu_wb_in;
                end else if (cpu_req_in) begin
                    miss_err = 1'b1;
                    rdata_d  = '0;
                end
            end
            ST_ACCESS: begin
                if (ready_sel) begin
                    sel_d = '0;
                    if (wb_q != 4'b0000)      rdata_d = '0;
                    else if (SWAP_MASK[idx_q]) rdata_d = swap_bytes(rdata_sel);
                    else                       rdata_d = rdata_sel;
                end else if (tmo_hit) begin
                    sel_d   = '0;
                    rdata_d = '0;
                    tmo_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A new error wins over a simultaneous clear; otherwise the first one sticks.
    always_comb begin
        err_irq_d   = err_irq_q;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;
        if ((miss_err || tmo_err) && (!err_irq_q || err_clr_in)) begin
            err_irq_d   = 1'b1;
            err_cause_d = miss_err ? 2'b01 : 2'b10;
            err_addr_d  = cpu_addr_in;
        end else if (err_clr_in) begin
            err_irq_d   = 1'b0;
            err_cause_d = 2'b00;
            err_addr_d  = '0;
        end
    end

    assign cpu_stall_out = (state_q == ST_IDLE && cpu_req_in) || (state_q == ST_ACCESS);
    assign cpu_rdata_out = rdata_q;
    assign s_sel_out     = sel_q;
    assign s_addr_out    = addr_q;
    assign s_wdata_out   = wdata_q;
    assign s_wb_out      = wb_q;
    assign err_irq_out   = err_irq_q;
    assign err_cause_out = err_cause_q;
    assign err_addr_out  = err_addr_q;
    assign dbg_state_out = state_q;

endmodule
